seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.

---
 rtl/seg7_scan_ctrl_pkg.sv | 19 +
 rtl/decoderBCD.sv | 13 +
 rtl/seg7_scan_tick.sv | 56 +++++
 rtl/seg7_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller: blank pattern, scan states
// and the active-low gfedcba hex decode table.
package seg7_scan_ctrl_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_GAP  = 2'd1,
      ST_SHOW = 2'd2
   } scan_state_e;

   // Entry k is the pattern for hex value k (listed F down to 0).
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/decoderBCD.sv
// Hex nibble to active-low gfedcba segment pattern, purely combinational.
module decoderBCD
   import seg7_scan_ctrl_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_TABLE[nibble];
   end

endmodule

// File: rtl/seg7_scan_tick.sv
// Slot prescaler and digit index for multiplexed scanners; both are held at zero
// whenever run is low so a restart always begins at digit 0.
module seg7_scan_tick #(
   parameter int DIV        = 50000,
   parameter int NUM_DIGITS = 4,
   parameter int CW         = $clog2(DIV),
   parameter int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   output logic          tick,
   output logic          wrap,
   output logic [IW-1:0] idx,
   output logic [CW-1:0] cnt
);

   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [CW-1:0] cnt_d, cnt_q;
   logic [IW-1:0] idx_d, idx_q;

   always_comb begin
      tick  = run && (cnt_q == CNT_LAST);
      wrap  = tick && (idx_q == IDX_LAST);
      cnt_d = {CW{1'b0}};
      idx_d = {IW{1'b0}};
      if (run) begin
         if (tick) begin
            cnt_d = {CW{1'b0}};
            idx_d = (idx_q == IDX_LAST) ? {IW{1'b0}} : idx_q + IW'(1);
         end else begin
            cnt_d = cnt_q + CW'(1);
            idx_d = idx_q;
         end
      end else begin
         cnt_d = {CW{1'b0}};
         idx_d = {IW{1'b0}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {CW{1'b0}};
         idx_q <= {IW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   assign idx = idx_q;
   assign cnt = cnt_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit common-anode 7-segment scan controller with frame-coherent data commit
// and a blank gap at the start of every digit slot to suppress ghosting.
module seg7_scan_ctrl
   import seg7_scan_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DIV        = 50000,
   parameter int GAP        = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   output logic                    load_ack,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an
);

   localparam int CW = $clog2(DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);

   scan_state_e state_d, state_q;

   logic                         run_s, tick_s, wrap_s, show_s;
   logic [IW-1:0]                idx_s;
   logic [CW-1:0]                cnt_s;
   logic [3:0]                   nib_s;
   logic [6:0]                   dec_s;

   logic [NUM_DIGITS-1:0][3:0]   stg_data_d, stg_data_q, act_data_d, act_data_q;
   logic [NUM_DIGITS-1:0]        stg_dp_d, stg_dp_q, act_dp_d, act_dp_q;
   logic [NUM_DIGITS-1:0]        stg_blank_d, stg_blank_q, act_blank_d, act_blank_q;
   logic                         pending_d, pending_q;
   logic                         ack_d, ack_q;
   logic [6:0]                   seg_d, seg_q;
   logic                         dp_d, dp_q;
   logic [NUM_DIGITS-1:0]        an_d, an_q;

   assign run_s = enable && (state_q != ST_OFF);

   seg7_scan_tick #(
      .DIV        (DIV),
      .NUM_DIGITS (NUM_DIGITS),
      .CW         (CW),
      .IW         (IW)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .run  (run_s),
      .tick (tick_s),
      .wrap (wrap_s),
      .idx  (idx_s),
      .cnt  (cnt_s)
   );

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF:  state_d = (GAP == 0) ? ST_SHOW : ST_GAP;
            ST_GAP:  state_d = (cnt_s == GAP_LAST) ? ST_SHOW : ST_GAP;
            ST_SHOW: begin
               if (tick_s) begin
                  state_d = (GAP == 0) ? ST_SHOW : ST_GAP;
               end else begin
                  state_d = ST_SHOW;
               end
            end
            default: state_d = ST_OFF;
         endcase
      end
   end

   // A load in the wrap cycle wins: it restages and the commit waits one more frame.
   always_comb begin
      stg_data_d  = stg_data_q;
      stg_dp_d    = stg_dp_q;
      stg_blank_d = stg_blank_q;
      act_data_d  = act_data_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
      pending_d   = pending_q;
      ack_d       = 1'b0;
      if (load) begin
         stg_data_d  = data_in;
         stg_dp_d    = dp_in;
         stg_blank_d = blank_in;
         pending_d   = 1'b1;
      end else if (wrap_s && pending_q) begin
         act_data_d  = stg_data_q;
         act_dp_d    = stg_dp_q;
         act_blank_d = stg_blank_q;
         pending_d   = 1'b0;
         ack_d       = 1'b1;
      end else begin
         pending_d   = pending_q;
      end
   end

   assign nib_s = act_data_q[idx_s];

   decoderBCD u_dec (
      .nibble (nib_s),
      .seg_n  (dec_s)
   );

   // enable gates the outputs directly so the display goes dark on the next edge.
   always_comb begin
      show_s = enable && (state_q == ST_SHOW) && !act_blank_q[idx_s];
      seg_d  = SEG_OFF;
      dp_d   = 1'b1;
      an_d   = {NUM_DIGITS{1'b1}};
      if (show_s) begin
         seg_d       = dec_s;
         dp_d        = ~act_dp_q[idx_s];
         an_d[idx_s] = 1'b0;
      end else begin
         seg_d = SEG_OFF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_OFF;
         stg_data_q  <= '{default: 4'h0};
         stg_dp_q    <= {NUM_DIGITS{1'b0}};
         stg_blank_q <= {NUM_DIGITS{1'b0}};
         act_data_q  <= '{default: 4'h0};
         act_dp_q    <= {NUM_DIGITS{1'b0}};
         act_blank_q <= {NUM_DIGITS{1'b0}};
         pending_q   <= 1'b0;
         ack_q       <= 1'b0;
         seg_q       <= SEG_OFF;
         dp_q        <= 1'b1;
         an_q        <= {NUM_DIGITS{1'b1}};
      end else begin
         state_q     <= state_d;
         stg_data_q  <= stg_data_d;
         stg_dp_q    <= stg_dp_d;
         stg_blank_q <= stg_blank_d;
         act_data_q  <= act_data_d;
         act_dp_q    <= act_dp_d;
         act_blank_q <= act_blank_d;
         pending_q   <= pending_d;
         ack_q       <= ack_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         an_q        <= an_d;
      end
   end

   assign load_ack = ack_q;
   assign seg      = seg_q;
   assign dp       = dp_q;
   assign an       = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Cycle scoreboard bench for seg7_scan_ctrl with N=4, DIV=8, GAP=2.
module tb_seg7_scan_ctrl;

   localparam int N   = 4;
   localparam int DIV = 8;
   localparam int GAP = 2;

   logic        clk = 1'b0;
   logic        rst, enable, load;
   logic [15:0] data_in;
   logic [3:0]  dp_in, blank_in;
   logic        load_ack, dp;
   logic [6:0]  seg;
   logic [3:0]  an;

   int total = 0;
   int bad   = 0;
   int ack_seen = 0;
   int d_seen = 0;

   // reference model state
   bit          m_run, m_pend;
   int          m_pos;
   logic [15:0] m_stg_d, m_act_d;
   logic [3:0]  m_stg_dp, m_act_dp, m_stg_bl, m_act_bl;
   logic [31:0] exp_q[$];

   seg7_scan_ctrl #(.NUM_DIGITS(N), .DIV(DIV), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .enable(enable), .load(load), .data_in(data_in),
      .dp_in(dp_in), .blank_in(blank_in), .load_ack(load_ack), .seg(seg),
      .dp(dp), .an(an)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] dec7(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   function automatic bit wrap_next();
      return m_run && enable && (m_pos % DIV == DIV - 1) && ((m_pos / DIV) % N == N - 1);
   endfunction

   function automatic logic [31:0] dark_vec();
      return {19'd0, 1'b0, 1'b1, 7'h7F, 4'hF};
   endfunction

   // One clock: predict the post-edge outputs, advance the model, compare.
   task automatic step(input string tag);
      logic [31:0] e;
      logic [3:0]  an_e;
      int          c, ix;
      bit          wrap, show, ack;
      e = dark_vec();
      if (rst) begin
         m_run = 0; m_pos = 0; m_pend = 0;
         m_stg_d = 16'h0; m_act_d = 16'h0;
         m_stg_dp = 4'h0; m_act_dp = 4'h0; m_stg_bl = 4'h0; m_act_bl = 4'h0;
      end else begin
         c    = m_pos % DIV;
         ix   = (m_pos / DIV) % N;
         show = m_run && enable && (c >= GAP) && !m_act_bl[ix];
         wrap = wrap_next();
         ack  = wrap && m_pend && !load;
         an_e = 4'hF;
         if (show) begin
            an_e[ix] = 1'b0;
            e = {19'd0, ack, ~m_act_dp[ix], dec7(m_act_d[4*ix +: 4]), an_e};
         end else begin
            e = {19'd0, ack, 1'b1, 7'h7F, 4'hF};
         end
         if (load) begin
            m_stg_d = data_in; m_stg_dp = dp_in; m_stg_bl = blank_in; m_pend = 1;
         end else if (ack) begin
            m_act_d = m_stg_d; m_act_dp = m_stg_dp; m_act_bl = m_stg_bl; m_pend = 0;
         end
         if (!enable) begin
            m_run = 0; m_pos = 0;
         end else if (!m_run) begin
            m_run = 1; m_pos = 0;
         end else begin
            m_pos++;
         end
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (load_ack) ack_seen++;
      if (an == 4'hD) d_seen++;
      check_val(tag, {19'd0, load_ack, dp, seg, an}, exp_q.pop_front());
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b, input string tag);
      load = 1'b1; data_in = d; dp_in = p; blank_in = b;
      step(tag);
      load = 1'b0;
   endtask

   task automatic run_steps(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   initial begin
      int guard;
      rst = 1'b1; enable = 1'b0; load = 1'b0;
      data_in = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
      #2;
      check_val("rst_async", {19'd0, load_ack, dp, seg, an}, dark_vec());
      run_steps(3, "rst_hold");
      rst = 1'b0;

      // 1: idle after reset
      run_steps(50, "reset_idle");

      // 2: scan order; first frame shows the zeroed active data
      do_load(16'h12AF, 4'b0100, 4'b0000, "load1");
      enable = 1'b1;
      ack_seen = 0;
      guard = 0;
      while (ack_seen == 0 && guard < 100) begin
         step("scan_pre");
         guard++;
      end
      check_val("ack_wait", 32'(ack_seen), 32'd1);
      run_steps(64, "scan");

      // 3: coherent mid-frame load
      run_steps(12, "pre_mid");
      ack_seen = 0;
      do_load(16'h0000, 4'b0000, 4'b0000, "load_mid");
      run_steps(40, "coherence");
      check_val("ack_once", 32'(ack_seen), 32'd1);

      // 4: load exactly on the wrap cycle
      guard = 0;
      while (!wrap_next() && guard < 64) begin
         step("seek_wrap");
         guard++;
      end
      check_val("wrap_found", 32'(wrap_next()), 32'd1);
      ack_seen = 0;
      do_load(16'h3C5E, 4'b0001, 4'b0000, "load_wrap");
      check_val("no_ack_at_wrap", 32'(ack_seen), 32'd0);
      run_steps(40, "after_wrap");
      check_val("ack_next_wrap", 32'(ack_seen), 32'd1);

      // 5: blanked digit, then disable mid-SHOW and re-enable
      do_load(16'h4567, 4'b0000, 4'b0010, "load_blank");
      run_steps(40, "blank_commit");
      d_seen = 0;
      run_steps(64, "blank");
      check_val("blank_an", 32'(d_seen), 32'd0);
      guard = 0;
      while (!(m_run && (m_pos % DIV) == GAP + 2) && guard < 64) begin
         step("seek_show");
         guard++;
      end
      enable = 1'b0;
      step("disable");
      run_steps(5, "dark");
      enable = 1'b1;
      run_steps(20, "reenable");

      // 6: async reset with a pending load
      run_steps(5, "pre_rst");
      do_load(16'hFFFF, 4'b1111, 4'b0000, "load_lost");
      run_steps(3, "pend");
      #3;
      rst = 1'b1;
      #1;
      check_val("rst_mid", {19'd0, load_ack, dp, seg, an}, dark_vec());
      run_steps(2, "rst_hold2");
      rst = 1'b0;
      ack_seen = 0;
      run_steps(80, "post_rst");
      check_val("pend_lost", 32'(ack_seen), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
